// File: rtl/dtw_ref_banked.sv
// Banked reference store for the DTW accelerator: one bank loads from the source
// FIFO while a DTW core reads another, already-valid bank.

module dtw_core_ref_mem #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int initalize  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam logic [WIDTH-1:0] INIT_WORD = WIDTH'(initalize);

    logic [WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only advances while enabled, so an idle bank keeps its last word.
    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= INIT_WORD;
        end else begin
            data_q <= data_d;
        end
    end

    assign rdata = data_q;

endmodule

module dtw_ref_banked #(
    parameter int WIDTH            = 16,
    parameter int REFMEM_PTR_WIDTH = 20,
    parameter int NUM_BANKS        = 2,
    parameter int BANK_SEL_WIDTH   = 1,
    parameter int REF_INIT         = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_start_in,
    input  logic [BANK_SEL_WIDTH-1:0]   load_bank_in,
    input  logic [REFMEM_PTR_WIDTH-1:0] ref_len_in,
    input  logic                        load_abort_in,
    output logic                        src_fifo_clear_out,
    output logic                        src_fifo_rden_out,
    input  logic                        src_fifo_empty_in,
    input  logic [WIDTH-1:0]            src_fifo_data_in,
    input  logic                        rd_start_in,
    input  logic [BANK_SEL_WIDTH-1:0]   rd_bank_in,
    input  logic                        dtw_done_in,
    input  logic [REFMEM_PTR_WIDTH-1:0] dtw_read_addr_in,
    output logic [WIDTH-1:0]            ref_data_out,
    output logic                        rd_oob_out,
    output logic [REFMEM_PTR_WIDTH-1:0] ref_len_out,
    output logic                        rd_active_out,
    output logic [NUM_BANKS-1:0]        bank_valid_out,
    output logic                        load_busy_out,
    output logic                        cmd_err_out,
    output logic [1:0]                  dbg_load_state_out,
    output logic [REFMEM_PTR_WIDTH-1:0] dbg_load_addr_out
);

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_LOAD = 2'd1,
        L_DONE = 2'd2
    } load_state_t;

    localparam logic [BANK_SEL_WIDTH:0]   NUM_BANKS_W = NUM_BANKS[BANK_SEL_WIDTH:0];
    localparam logic [REFMEM_PTR_WIDTH-1:0] PTR_ONE   = REFMEM_PTR_WIDTH'(1);

    load_state_t                 state_q, state_d;
    logic [BANK_SEL_WIDTH-1:0]   ld_bank_q, ld_bank_d;
    logic [BANK_SEL_WIDTH-1:0]   rd_bank_q, rd_bank_d;
    logic [REFMEM_PTR_WIDTH-1:0] ld_len_q, ld_len_d;
    logic [REFMEM_PTR_WIDTH-1:0] ptr_q, ptr_d;
    logic [REFMEM_PTR_WIDTH-1:0] ref_len_q, ref_len_d;
    logic [REFMEM_PTR_WIDTH-1:0] bank_len_q [NUM_BANKS];
    logic [REFMEM_PTR_WIDTH-1:0] bank_len_d [NUM_BANKS];
    logic [NUM_BANKS-1:0]        valid_q, valid_d;
    logic                        rd_active_q, rd_active_d;
    logic                        oob_q, oob_d;
    logic                        cmd_err_q, cmd_err_d;

    logic                        ld_bank_ok, rd_bank_ok, ld_ok, rd_ok, rden;
    logic [REFMEM_PTR_WIDTH-1:0] mem_addr  [NUM_BANKS];
    logic                        mem_we    [NUM_BANKS];
    logic                        mem_en    [NUM_BANKS];
    logic [WIDTH-1:0]            mem_rdata [NUM_BANKS];

    // A same-cycle read of a valid bank beats a load of that bank; a bank under load is never readable.
    always_comb begin
        ld_bank_ok = {1'b0, load_bank_in} < NUM_BANKS_W;
        rd_bank_ok = {1'b0, rd_bank_in} < NUM_BANKS_W;
        rd_ok = rd_start_in && !rd_active_q && rd_bank_ok && valid_q[rd_bank_in]
                && !((state_q != L_IDLE) && (ld_bank_q == rd_bank_in));
        ld_ok = load_start_in && (state_q == L_IDLE) && (ref_len_in != '0) && ld_bank_ok
                && !(rd_active_q && (rd_bank_q == load_bank_in))
                && !(rd_ok && (rd_bank_in == load_bank_in));
        rden  = (state_q == L_LOAD) && !src_fifo_empty_in && (ptr_q < ld_len_q) && !load_abort_in;
    end

    always_comb begin
        state_d     = state_q;
        ld_bank_d   = ld_bank_q;
        ld_len_d    = ld_len_q;
        ptr_d       = ptr_q;
        valid_d     = valid_q;
        bank_len_d  = bank_len_q;
        rd_active_d = rd_active_q;
        rd_bank_d   = rd_bank_q;
        ref_len_d   = ref_len_q;
        oob_d       = oob_q;
        cmd_err_d   = (load_start_in && !ld_ok) || (rd_start_in && !rd_ok);

        case (state_q)
            L_IDLE: begin
                if (ld_ok) begin
                    ld_bank_d              = load_bank_in;
                    ld_len_d               = ref_len_in;
                    ptr_d                  = '0;
                    valid_d[load_bank_in]  = 1'b0;
                    state_d                = L_LOAD;
                end
            end
            L_LOAD: begin
                if (load_abort_in) begin
                    state_d = L_IDLE;
                end else if (rden) begin
                    ptr_d = ptr_q + PTR_ONE;
                    if (ptr_q == ld_len_q - PTR_ONE) begin
                        state_d = L_DONE;
                    end
                end
            end
            L_DONE: begin
                valid_d[ld_bank_q]    = 1'b1;
                bank_len_d[ld_bank_q] = ld_len_q;
                state_d               = L_IDLE;
            end
            default: state_d = L_IDLE;
        endcase

        if (rd_active_q) begin
            oob_d = dtw_read_addr_in >= ref_len_q;
            if (dtw_done_in) begin
                rd_active_d = 1'b0;
            end
        end else if (rd_ok) begin
            rd_active_d = 1'b1;
            rd_bank_d   = rd_bank_in;
            ref_len_d   = bank_len_q[rd_bank_in];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= L_IDLE;
            ld_bank_q   <= '0;
            ld_len_q    <= '0;
            ptr_q       <= '0;
            valid_q     <= '0;
            rd_active_q <= 1'b0;
            rd_bank_q   <= '0;
            ref_len_q   <= '0;
            oob_q       <= 1'b0;
            cmd_err_q   <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_len_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ld_bank_q   <= ld_bank_d;
            ld_len_q    <= ld_len_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            rd_active_q <= rd_active_d;
            rd_bank_q   <= rd_bank_d;
            ref_len_q   <= ref_len_d;
            oob_q       <= oob_d;
            cmd_err_q   <= cmd_err_d;
            bank_len_q  <= bank_len_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            mem_we[i]   = rden && (ld_bank_q == BANK_SEL_WIDTH'(i));
            mem_en[i]   = rd_active_q && (rd_bank_q == BANK_SEL_WIDTH'(i));
            mem_addr[i] = mem_we[i] ? ptr_q : dtw_read_addr_in;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        dtw_core_ref_mem #(
            .WIDTH      (WIDTH),
            .ADDR_WIDTH (REFMEM_PTR_WIDTH),
            .initalize  (REF_INIT)
        ) u_mem (
            .clk   (clk),
            .rst   (rst),
            .en    (mem_en[g]),
            .we    (mem_we[g]),
            .addr  (mem_addr[g]),
            .wdata (src_fifo_data_in),
            .rdata (mem_rdata[g])
        );
    end

    assign src_fifo_clear_out = (state_q == L_IDLE);
    assign src_fifo_rden_out  = rden;
    assign load_busy_out      = (state_q == L_LOAD);
    assign ref_data_out       = mem_rdata[rd_bank_q];
    assign rd_oob_out         = oob_q;
    assign ref_len_out        = ref_len_q;
    assign rd_active_out      = rd_active_q;
    assign bank_valid_out     = valid_q;
    assign cmd_err_out        = cmd_err_q;
    assign dbg_load_state_out = state_q;
    assign dbg_load_addr_out  = ptr_q;

endmodule

// File: tb/tb_dtw_ref_banked.sv
// Randomized bench for dtw_ref_banked: an FWFT FIFO model feeds loads and a
// per-bank array model predicts read data, bounds flags, valid bits and command errors.

module tb_dtw_ref_banked;

    localparam int WIDTH = 16;
    localparam int PW    = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_start_in, load_abort_in, rd_start_in, dtw_done_in;
    logic [0:0]       load_bank_in, rd_bank_in;
    logic [PW-1:0]    ref_len_in, dtw_read_addr_in;
    logic             src_fifo_clear_out, src_fifo_rden_out, src_fifo_empty_in;
    logic [WIDTH-1:0] src_fifo_data_in, ref_data_out;
    logic             rd_oob_out, rd_active_out, load_busy_out, cmd_err_out;
    logic [PW-1:0]    ref_len_out, dbg_load_addr_out;
    logic [1:0]       bank_valid_out, dbg_load_state_out;

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] fifoMem [256];
    int          fifoWr = 0;
    int          fifoRd = 0;
    logic        stall  = 1'b0;

    logic [15:0] modelMem [2][64];
    int          modelLen [2];
    bit          modelValid [2];

    dtw_ref_banked dut (
        .clk                (clk),
        .rst                (rst),
        .load_start_in      (load_start_in),
        .load_bank_in       (load_bank_in),
        .ref_len_in         (ref_len_in),
        .load_abort_in      (load_abort_in),
        .src_fifo_clear_out (src_fifo_clear_out),
        .src_fifo_rden_out  (src_fifo_rden_out),
        .src_fifo_empty_in  (src_fifo_empty_in),
        .src_fifo_data_in   (src_fifo_data_in),
        .rd_start_in        (rd_start_in),
        .rd_bank_in         (rd_bank_in),
        .dtw_done_in        (dtw_done_in),
        .dtw_read_addr_in   (dtw_read_addr_in),
        .ref_data_out       (ref_data_out),
        .rd_oob_out         (rd_oob_out),
        .ref_len_out        (ref_len_out),
        .rd_active_out      (rd_active_out),
        .bank_valid_out     (bank_valid_out),
        .load_busy_out      (load_busy_out),
        .cmd_err_out        (cmd_err_out),
        .dbg_load_state_out (dbg_load_state_out),
        .dbg_load_addr_out  (dbg_load_addr_out)
    );

    always #5 clk = ~clk;

    // First-word-fall-through source FIFO; clear discards everything queued.
    assign src_fifo_empty_in = (fifoWr == fifoRd) || stall;
    assign src_fifo_data_in  = fifoMem[fifoRd[7:0]];

    always @(posedge clk) begin
        if (src_fifo_clear_out === 1'b1) fifoRd <= fifoWr;
        else if (src_fifo_rden_out === 1'b1) fifoRd <= fifoRd + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] validVec();
        return {modelValid[1], modelValid[0]};
    endfunction

    task automatic loadBank(input int bank, input int len, input bit fixedWords,
                            input int abortAfter, input int gapAt, input int gapLen);
        logic [15:0] words [64];
        int written = 0;
        int gapDone = 0;
        bit aborted = 0;
        load_start_in = 1'b1;
        load_bank_in  = 1'(bank);
        ref_len_in    = PW'(len);
        tick();
        load_start_in = 1'b0;
        modelValid[bank] = 0;
        checkOutput("ld_accept_err", cmd_err_out, 0);
        checkOutput("ld_busy", load_busy_out, 1);
        checkOutput("ld_valid_clr", bank_valid_out, validVec());
        for (int i = 0; i < len; i++) begin
            words[i] = fixedWords ? 16'((i + 1) * 16'h11) : 16'($urandom);
            fifoMem[fifoWr[7:0]] = words[i];
            fifoWr++;
        end
        for (int cyc = 0; cyc < 400 && written < len && !aborted; cyc++) begin
            stall = (written == gapAt) && (gapDone < gapLen);
            if (stall) gapDone++;
            load_abort_in = (written == abortAfter);
            #1;
            checkOutput("ld_ptr", dbg_load_addr_out, written);
            checkOutput("ld_rden", src_fifo_rden_out, !stall && !load_abort_in);
            if (load_abort_in) aborted = 1;
            else if (!stall) written++;
            tick();
        end
        stall = 1'b0;
        load_abort_in = 1'b0;
        if (aborted) begin
            checkOutput("abort_state", dbg_load_state_out, 0);
            checkOutput("abort_clear", src_fifo_clear_out, 1);
            checkOutput("abort_valid", bank_valid_out, validVec());
        end else if (written == len) begin
            checkOutput("done_state", dbg_load_state_out, 2);
            checkOutput("done_busy", load_busy_out, 0);
            tick();
            for (int i = 0; i < len; i++) modelMem[bank][i] = words[i];
            modelLen[bank]   = len;
            modelValid[bank] = 1;
            checkOutput("ld_valid_set", bank_valid_out, validVec());
            checkOutput("ld_idle", dbg_load_state_out, 0);
            checkOutput("ld_clear", src_fifo_clear_out, 1);
        end else begin
            checkOutput("ld_timeout", 0, 1);
        end
    endtask

    task automatic startRead(input int bank, input bit expectOk);
        rd_start_in = 1'b1;
        rd_bank_in  = 1'(bank);
        tick();
        rd_start_in = 1'b0;
        checkOutput("rd_active", rd_active_out, expectOk);
        checkOutput("rd_cmd_err", cmd_err_out, !expectOk);
        if (expectOk) checkOutput("rd_len", ref_len_out, modelLen[bank]);
    endtask

    task automatic readAddrs(input int bank, input int n, input bit sequential);
        int a;
        for (int i = 0; i < n; i++) begin
            a = sequential ? i : int'($urandom_range(0, modelLen[bank] + 2));
            dtw_read_addr_in = PW'(a);
            tick();
            checkOutput("rd_oob", rd_oob_out, a >= modelLen[bank]);
            if (a < modelLen[bank]) checkOutput("rd_data", ref_data_out, modelMem[bank][a]);
        end
    endtask

    task automatic endRead();
        dtw_done_in = 1'b1;
        tick();
        dtw_done_in = 1'b0;
        checkOutput("rd_end", rd_active_out, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_active"}, rd_active_out, 0);
        checkOutput({tag, "_valid"}, bank_valid_out, 0);
        checkOutput({tag, "_busy"}, load_busy_out, 0);
        checkOutput({tag, "_cmd_err"}, cmd_err_out, 0);
        checkOutput({tag, "_oob"}, rd_oob_out, 0);
        checkOutput({tag, "_ref_len"}, ref_len_out, 0);
        checkOutput({tag, "_rden"}, src_fifo_rden_out, 0);
        checkOutput({tag, "_clear"}, src_fifo_clear_out, 1);
        checkOutput({tag, "_state"}, dbg_load_state_out, 0);
    endtask

    task automatic applyStimulus();
        int b, o, len, ab, gAt, gLen;
        // Directed: fixed pattern load, sequential read-back with one out-of-bounds address.
        loadBank(0, 4, 1, -1, -1, 0);
        checkOutput("valid_01", bank_valid_out, 2'b01);
        startRead(0, 1);
        readAddrs(0, 5, 1);
        endRead();

        loadBank(1, 6, 0, -1, 3, 3);
        startRead(1, 1);
        readAddrs(1, 8, 0);
        endRead();

        // Ping-pong: bank0 read session while bank1 reloads.
        startRead(0, 1);
        fork
            loadBank(1, 8, 0, -1, -1, 0);
            readAddrs(0, 14, 0);
        join
        checkOutput("valid_11", bank_valid_out, 2'b11);
        load_start_in = 1'b1;
        load_bank_in  = 1'b0;
        ref_len_in    = PW'(5);
        tick();
        load_start_in = 1'b0;
        checkOutput("ld_on_rd_err", cmd_err_out, 1);
        checkOutput("ld_on_rd_state", dbg_load_state_out, 0);
        tick();
        checkOutput("err_pulse_width", cmd_err_out, 0);
        readAddrs(0, 4, 0);
        endRead();

        loadBank(1, 5, 0, 2, -1, 0);
        startRead(1, 0);

        // Same-cycle load and read of a valid bank: read wins.
        load_start_in = 1'b1;
        load_bank_in  = 1'b0;
        ref_len_in    = PW'(3);
        rd_start_in   = 1'b1;
        rd_bank_in    = 1'b0;
        tick();
        load_start_in = 1'b0;
        rd_start_in   = 1'b0;
        checkOutput("same_rd_active", rd_active_out, 1);
        checkOutput("same_err", cmd_err_out, 1);
        checkOutput("same_state", dbg_load_state_out, 0);
        checkOutput("same_valid", bank_valid_out, validVec());
        readAddrs(0, 3, 0);

        dtw_done_in = 1'b1;
        rd_start_in = 1'b1;
        rd_bank_in  = 1'b0;
        tick();
        dtw_done_in = 1'b0;
        rd_start_in = 1'b0;
        checkOutput("done_start_active", rd_active_out, 0);
        checkOutput("done_start_err", cmd_err_out, 1);

        load_start_in = 1'b1;
        load_bank_in  = 1'b1;
        ref_len_in    = '0;
        tick();
        load_start_in = 1'b0;
        checkOutput("len0_err", cmd_err_out, 1);
        checkOutput("len0_state", dbg_load_state_out, 0);
        startRead(1, 0);

        // Randomized loads, ping-pong reads, gaps and aborts.
        for (int it = 0; it < 10; it++) begin
            b    = int'($urandom_range(0, 1));
            o    = 1 - b;
            len  = int'($urandom_range(1, 20));
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            gAt  = int'($urandom_range(0, len - 1));
            gLen = int'($urandom_range(0, 3));
            if (modelValid[o]) begin
                startRead(o, 1);
                fork
                    loadBank(b, len, 0, ab, gAt, gLen);
                    readAddrs(o, len + 4, 0);
                join
                endRead();
            end else begin
                loadBank(b, len, 0, ab, gAt, gLen);
            end
            startRead(b, modelValid[b]);
            if (modelValid[b]) begin
                readAddrs(b, 6, 0);
                endRead();
            end
        end

        // Asynchronous reset mid-read and mid-load.
        loadBank(0, 6, 0, -1, -1, 0);
        startRead(0, 1);
        load_start_in = 1'b1;
        load_bank_in  = 1'b1;
        ref_len_in    = PW'(10);
        tick();
        load_start_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fifoMem[fifoWr[7:0]] = 16'($urandom);
            fifoWr++;
        end
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        modelValid[0] = 0;
        modelValid[1] = 0;
        modelLen[0]   = 0;
        modelLen[1]   = 0;
        tick();
        startRead(0, 0);
    endtask

    initial begin
        rst = 1'b1;
        load_start_in = 1'b0;
        load_abort_in = 1'b0;
        rd_start_in   = 1'b0;
        dtw_done_in   = 1'b0;
        load_bank_in  = '0;
        rd_bank_in    = '0;
        ref_len_in    = '0;
        dtw_read_addr_in = '0;
        modelValid[0] = 0;
        modelValid[1] = 0;
        modelLen[0]   = 0;
        modelLen[1]   = 0;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
